seq_addsub: RTL
===============

Name: seq_addsub

Overview:
- Parametrised, multi-cycle digit-serial adder/subtractor. Successor to the team's fixed-width 3-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock. Each digit slice is a DIGIT-bit ripple of full-adder cells.
- Uses valid/ready handshakes on both the input and output sides.
- Used where a full-width ripple chain would not close timing, and where operand traffic is sparse.

Parameters:
- WIDTH, 8: operand and result width in bits; must be 2 or more.
- DIGIT, 2: bits processed per clock; must divide WIDTH exactly; DIGIT = WIDTH gives single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  an operand set is presented.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; when sub=1, 1 means no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (asynchronous assert, any state):
  - state returns to IDLE.
  - in_ready=0 while rst is high, then 1 in IDLE.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - Any in-flight operation is discarded, with no partial output.
- State IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1 at the edge (accept), the block latches:
    - A register = a.
    - B register = sub ? ~b : b.
    - carry register = sub ? ~cin : cin.
    - digit counter = 0.
  - Then goes to RUN.
  - a, b, sub and cin are sampled only at the accept edge; later changes are ignored.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds the low DIGIT bits of A and B plus the carry register.
  - The DIGIT result bits are shifted into the result register from the MSB end. A and B shift right by DIGIT. The carry register takes the slice carry-out.
  - On the last digit (counter = WIDTH/DIGIT - 1), also capture:
    - cout = final carry.
    - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Then go to DONE.
- State DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are stable for as long as out_valid=1.
  - If out_ready=1 at the edge, go to IDLE.
  - sum, cout and ovf keep their values until the next result completes.
- Latency and throughput:
  - With the accept at edge 0, out_valid rises after edge WIDTH/DIGIT.
  - Minimum spacing between accepts is WIDTH/DIGIT + 2 cycles: an IDLE cycle is always needed after DONE, because in_ready stays 0 in DONE even when out_ready=1.
- Arithmetic:
  - Result is (a + b + cin) mod 2^WIDTH, or (a - b - cin) mod 2^WIDTH.
  - Identical for signed and unsigned operands; only ovf is signed-specific.
- Boundary cases:
  - in_valid held high across RUN/DONE: not re-accepted until IDLE.
  - out_ready held low: DONE holds indefinitely, with no loss or change of the result.
  - DIGIT = WIDTH: RUN lasts exactly one cycle.
  - Reset deasserted while in_valid=1: the first accept happens at the first edge after deassertion.

Test Plan:
1. WIDTH=8, DIGIT=2. a=0x5A, b=0x3C, sub=0, cin=0 → sum=0x96, cout=0, ovf=1. out_valid rises exactly 4 edges after the accept.
2. WIDTH=8, DIGIT=2. a=0xFF, b=0x01, sub=0, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
3. Subtraction checks:
   - a=0x10, b=0x01, sub=1, cin=0 → sum=0x0F, cout=1, ovf=0.
   - a=0x00, b=0x01, sub=1 → sum=0xFF, cout=0 (borrow), ovf=0.
   - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
4. Backpressure: hold out_ready=0 for 6 cycles in DONE, and change a/b every cycle with in_valid=1 → sum, cout and ovf unchanged, in_ready=0. Release → IDLE next cycle, then accept.
5. Reset mid-operation: assert rst asynchronously (between edges) during the 2nd RUN cycle → all outputs 0 immediately. After release, an operation with a=0x01, b=0x02 → sum=0x03, with no residue from the aborted operation.
6. Parameter sweep: DIGIT ∈ {1, 2, 4, 8} at WIDTH=8, and WIDTH=16 with DIGIT=4, on 1000 random operands each → results match a reference model. Latency equals WIDTH/DIGIT in every configuration.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: digit-serial adder/subtractor with valid/ready handshakes.
// Operands are accepted in IDLE, consumed DIGIT bits per clock in RUN
// (LSB digit first), and the result is presented in DONE until taken.
// Subtraction is carried out as a + ~b + ~cin, so cout=1 means no borrow.

// Protocol checker: output-side handshake properties of seq_addsub.
module seq_addsub_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] sum,
  input logic             cout,
  input logic             ovf
);

  // The block never offers to accept while it is presenting a result.
  a_no_overlap: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

  // A result that is not taken stays presented and unchanged.
  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout) && $stable(ovf)));

endmodule

module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  // Reject parameter sets the datapath cannot represent.
  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("seq_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One DIGIT-bit ripple of full-adder cells.
  // Returns {carry into the slice MSB, carry out of the slice, slice sum}.
  function automatic logic [DIGIT+1:0] slice_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             ci
  );
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[DIGIT-1], c[DIGIT], s};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;
  logic             idle_r;

  logic [DIGIT+1:0] slice_s;
  logic [DIGIT-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             slice_cmsb_s;
  logic [WIDTH-1:0] work_next_s;
  logic             last_s;

  // Current digit slice and the result register after shifting it in at the MSB end.
  always_comb begin
    slice_s      = slice_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    slice_sum_s  = slice_s[DIGIT-1:0];
    slice_cout_s = slice_s[DIGIT];
    slice_cmsb_s = slice_s[DIGIT+1];
    work_next_s  = (work_r >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));
    last_s       = (cnt_r == LAST_CNT);
  end

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and digit-serial datapath; result captured on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            work_r  <= '0;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= slice_cout_s;
          work_r  <= work_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r  <= work_next_s;
            cout_r <= slice_cout_s;
            ovf_r  <= slice_cmsb_s ^ slice_cout_s;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered handshake flags, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      out_valid_r <= (state_s == DONE);
      idle_r      <= (state_s == IDLE);
    end
  end

  // in_ready is forced low for as long as reset is held, and is live
  // immediately after release so the first edge can accept.
  assign in_ready  = idle_r & ~rst;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  seq_addsub_chk #(.WIDTH(WIDTH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

endmodule
